multicycle_control_unit: RTL and testbench

- Multicycle FSM controller for the 16-bit TSC CPU datapath. It sits directly upstream of the datapath and drives every mux select, latch enable and memory strobe from the latched instruction fields.
- Sequences each instruction through IF/ID/EX/MEM/WB, waits on the memory handshake, counts retired instructions and holds the HALT state.

---
 rtl/multicycle_control_unit.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle IF/ID/EX/MEM/WB controller for the 16-bit TSC datapath; strobes decode combinationally from state and IR fields.
// ILLEGAL_TRAP_EN: undefined opcode/func halts the core and raises sticky illegal_inst instead of retiring as a NOP.
module multicycle_control_unit #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 bcond,
  input  logic                 mem_ready,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_src,
  output logic [1:0]           alu_src_A,
  output logic [1:0]           alu_src_B,
  output logic [3:0]           alu_op,
  output logic                 next_pc_store,
  output logic                 branch_dst_store,
  output logic                 aluout_store,
  output logic                 mdr_store,
  output logic [1:0]           pc_src,
  output logic                 pvs_update,
  output logic                 output_en,
  output logic                 is_halted,
  output logic [WORD_SIZE-1:0] inst_count,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegal_inst,
`endif
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_e;

  localparam logic [3:0] OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_RTYPE = 4'd15;
  localparam logic [5:0] FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_OR = 4'd3, ALU_LHI = 4'd8, ALU_BNE = 4'd9;

  typedef struct packed {
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic [1:0] alu_src_A;
    logic [1:0] alu_src_B;
    logic [3:0] alu_op;
    logic       next_pc_store;
    logic       branch_dst_store;
    logic       aluout_store;
    logic       mdr_store;
    logic [1:0] pc_src;
    logic       pvs_update;
    logic       output_en;
  } ctrl_t;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] inst_count_q;
  logic                 halted_q;
  logic                 hlt_retire;
  ctrl_t                c, c_out;

  logic is_rtype, r_alu, is_branch, valid_inst;
  assign is_rtype   = (opcode == OP_RTYPE);
  assign r_alu      = is_rtype && (func[5:3] == 3'd0);
  assign is_branch  = (opcode[3:2] == 2'b00);
  assign valid_inst = (opcode <= OP_JAL) ||
                      (is_rtype && (r_alu || func == FN_JPR || func == FN_JRL ||
                                    func == FN_WWD || func == FN_HLT));

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, trap_hit;
`endif

  always_comb begin
    c          = '0;
    state_d    = state_q;
    hlt_retire = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap_hit   = 1'b0;
`endif
    case (state_q)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.alu_src_B = 2'd2;
        if (mem_ready) begin
          c.ir_write      = 1'b1;
          c.next_pc_store = 1'b1;
          state_d         = S_ID;
        end
      end
      S_ID: begin
        // Branch target is computed speculatively for every instruction.
        c.alu_src_A        = 2'd2;
        c.alu_src_B        = 2'd1;
        c.branch_dst_store = 1'b1;
        if (!valid_inst) begin
`ifdef ILLEGAL_TRAP_EN
          trap_hit     = 1'b1;
          state_d      = S_HALT;
`else
          c.pvs_update = 1'b1;
          state_d      = S_IF;
`endif
        end else if (opcode == OP_JMP || opcode == OP_JAL) begin
          c.pc_src     = 2'd2;
          c.pvs_update = 1'b1;
          if (opcode == OP_JAL) begin
            c.reg_write = 1'b1;
            c.reg_dst   = 2'd2;
            c.wb_src    = 2'd2;
          end
          state_d = S_IF;
        end else if (is_rtype && (func == FN_JPR || func == FN_JRL)) begin
          c.pc_src     = 2'd3;
          c.pvs_update = 1'b1;
          if (func == FN_JRL) begin
            c.reg_write = 1'b1;
            c.reg_dst   = 2'd2;
            c.wb_src    = 2'd2;
          end
          state_d = S_IF;
        end else if (is_rtype && func == FN_HLT) begin
          hlt_retire = 1'b1;
          state_d    = S_HALT;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        state_d = S_IF;
        if (is_branch) begin
          c.alu_src_A  = 2'd1;
          c.alu_op     = ALU_BNE + {2'b00, opcode[1:0]};
          c.pc_src     = bcond ? 2'd1 : 2'd0;
          c.pvs_update = 1'b1;
        end else if (opcode == OP_ADI || opcode == OP_ORI || opcode == OP_LHI) begin
          c.alu_src_A    = 2'd1;
          c.alu_src_B    = (opcode == OP_ORI) ? 2'd3 : 2'd1;
          c.alu_op       = (opcode == OP_ORI) ? ALU_OR :
                           (opcode == OP_LHI) ? ALU_LHI : ALU_ADD;
          c.aluout_store = 1'b1;
          state_d        = S_WB;
        end else if (opcode == OP_LWD || opcode == OP_SWD) begin
          c.alu_src_A    = 2'd1;
          c.alu_src_B    = 2'd1;
          c.aluout_store = 1'b1;
          state_d        = S_MEM;
        end else if (r_alu) begin
          c.alu_src_A    = 2'd1;
          c.alu_op       = func[3:0];
          c.aluout_store = 1'b1;
          state_d        = S_WB;
        end else if (is_rtype && func == FN_WWD) begin
          c.output_en  = 1'b1;
          c.pvs_update = 1'b1;
        end
      end
      S_MEM: begin
        c.i_or_d = 1'b1;
        if (opcode == OP_LWD) begin
          c.mem_read  = 1'b1;
          c.mdr_store = mem_ready;
        end else begin
          c.mem_write = 1'b1;
        end
        if (mem_ready) begin
          if (opcode == OP_LWD) begin
            state_d = S_WB;
          end else begin
            c.pvs_update = 1'b1;
            state_d      = S_IF;
          end
        end
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = r_alu ? 2'd1 : 2'd0;
        c.wb_src     = (opcode == OP_LWD) ? 2'd1 : 2'd0;
        c.pvs_update = 1'b1;
        state_d      = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // The reset cycle must never issue a memory or register side effect.
  assign c_out = reset ? '0 : c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IF;
      inst_count_q <= '0;
      halted_q     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
      if (c.pvs_update || hlt_retire)
        inst_count_q <= inst_count_q + 1'b1;
`ifdef ILLEGAL_TRAP_EN
      if (trap_hit)
        illegal_q <= 1'b1;
`endif
    end
  end

  assign ir_write         = c_out.ir_write;
  assign mem_read         = c_out.mem_read;
  assign mem_write        = c_out.mem_write;
  assign i_or_d           = c_out.i_or_d;
  assign reg_write        = c_out.reg_write;
  assign reg_dst          = c_out.reg_dst;
  assign wb_src           = c_out.wb_src;
  assign alu_src_A        = c_out.alu_src_A;
  assign alu_src_B        = c_out.alu_src_B;
  assign alu_op           = c_out.alu_op;
  assign next_pc_store    = c_out.next_pc_store;
  assign branch_dst_store = c_out.branch_dst_store;
  assign aluout_store     = c_out.aluout_store;
  assign mdr_store        = c_out.mdr_store;
  assign pc_src           = c_out.pc_src;
  assign pvs_update       = c_out.pvs_update;
  assign output_en        = c_out.output_en;
  assign is_halted        = halted_q;
  assign inst_count       = inst_count_q;
  assign state            = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_inst     = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected control vectors, queued when driven and compared mid-cycle.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset, bcond, mem_ready;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic [1:0]  reg_dst, wb_src, alu_src_A, alu_src_B, pc_src;
  logic [3:0]  alu_op;
  logic        next_pc_store, branch_dst_store, aluout_store, mdr_store;
  logic        pvs_update, output_en, is_halted;
  logic [15:0] inst_count;
  logic [2:0]  state;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_inst;
`endif

  always #5 clk = ~clk;

  multicycle_control_unit #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .bcond(bcond),
    .mem_ready(mem_ready), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_src(wb_src), .alu_src_A(alu_src_A),
    .alu_src_B(alu_src_B), .alu_op(alu_op), .next_pc_store(next_pc_store),
    .branch_dst_store(branch_dst_store), .aluout_store(aluout_store),
    .mdr_store(mdr_store), .pc_src(pc_src), .pvs_update(pvs_update),
    .output_en(output_en), .is_halted(is_halted), .inst_count(inst_count),
`ifdef ILLEGAL_TRAP_EN
    .illegal_inst(illegal_inst),
`endif
    .state(state)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        ir_write, mem_read, mem_write, i_or_d, reg_write;
    logic [1:0]  reg_dst, wb_src, a_src, b_src;
    logic [3:0]  alu_op;
    logic        npc, bdst, aluout, mdr;
    logic [1:0]  pc_src;
    logic        pvs, oen, halted, ill;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [15:0] ir;
    logic        bc;
    logic        rdy;
    exp_t        e;
    string       nm;
  } vec_t;

  vec_t  tbl[$];
  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic exp_t mk(logic [2:0] st, logic [15:0] cnt, logic halted);
    exp_t e;
    e = '0;
    e.st = st;
    e.cnt = cnt;
    e.halted = halted;
    return e;
  endfunction

  function automatic exp_t f_if(logic rdy, logic [15:0] cnt);
    exp_t e;
    e = mk(3'd0, cnt, 1'b0);
    e.mem_read = 1'b1;
    e.b_src = 2'd2;
    e.ir_write = rdy;
    e.npc = rdy;
    return e;
  endfunction

  function automatic exp_t f_id(logic [15:0] cnt);
    exp_t e;
    e = mk(3'd1, cnt, 1'b0);
    e.a_src = 2'd2;
    e.b_src = 2'd1;
    e.bdst = 1'b1;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.st = state;         a.ir_write = ir_write;   a.mem_read = mem_read;
    a.mem_write = mem_write; a.i_or_d = i_or_d;   a.reg_write = reg_write;
    a.reg_dst = reg_dst;  a.wb_src = wb_src;       a.a_src = alu_src_A;
    a.b_src = alu_src_B;  a.alu_op = alu_op;       a.npc = next_pc_store;
    a.bdst = branch_dst_store; a.aluout = aluout_store; a.mdr = mdr_store;
    a.pc_src = pc_src;    a.pvs = pvs_update;      a.oen = output_en;
    a.halted = is_halted; a.cnt = inst_count;
`ifdef ILLEGAL_TRAP_EN
    a.ill = illegal_inst;
`else
    a.ill = 1'b0;
`endif
    return a;
  endfunction

  task automatic add(input logic rst, input logic [15:0] ir, input logic bc,
                     input logic rdy, input exp_t e, input string nm);
    vec_t v;
    v.rst = rst; v.ir = ir; v.bc = bc; v.rdy = rdy; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Called just after a rising edge; drives one cycle and checks it at the falling edge.
  task automatic step(input logic rst, input logic [15:0] ir, input logic bc,
                      input logic rdy, input exp_t e, input string nm);
    exp_t  want, got;
    string wn;
    reset = rst; opcode = ir[15:12]; func = ir[5:0]; bcond = bc; mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    want = exp_q.pop_front();
    wn   = name_q.pop_front();
    got  = sample();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got state=%0d cnt=%0d vec=%h, expected state=%0d cnt=%0d vec=%h",
               wn, got.st, got.cnt, got, want.st, want.cnt, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // ---- table of per-cycle vectors ----
    add(1, 16'hF0C0, 0, 1, mk(3'd0, 16'd0, 1'b0), "reset_state");
    add(0, 16'hF0C0, 0, 1, f_if(1, 0), "add_if");
    add(0, 16'hF0C0, 0, 1, f_id(0), "add_id");
    e = mk(3'd2, 0, 0); e.a_src = 1; e.aluout = 1;
    add(0, 16'hF0C0, 0, 1, e, "add_ex");
    e = mk(3'd4, 0, 0); e.reg_write = 1; e.reg_dst = 1; e.pvs = 1;
    add(0, 16'hF0C0, 0, 1, e, "add_wb");

    add(0, 16'h7101, 0, 0, f_if(0, 1), "lwd_if_wait");
    add(0, 16'h7101, 0, 1, f_if(1, 1), "lwd_if");
    add(0, 16'h7101, 0, 1, f_id(1), "lwd_id");
    e = mk(3'd2, 1, 0); e.a_src = 1; e.b_src = 1; e.aluout = 1;
    add(0, 16'h7101, 0, 1, e, "lwd_ex");
    e = mk(3'd3, 1, 0); e.i_or_d = 1; e.mem_read = 1;
    for (int i = 0; i < 3; i++) add(0, 16'h7101, 0, 0, e, "lwd_mem_wait");
    e.mdr = 1;
    add(0, 16'h7101, 0, 1, e, "lwd_mem_rdy");
    e = mk(3'd4, 1, 0); e.reg_write = 1; e.wb_src = 1; e.pvs = 1;
    add(0, 16'h7101, 0, 1, e, "lwd_wb");

    add(0, 16'h1000, 1, 1, f_if(1, 2), "beq_t_if");
    add(0, 16'h1000, 1, 1, f_id(2), "beq_t_id");
    e = mk(3'd2, 2, 0); e.a_src = 1; e.alu_op = 10; e.pc_src = 1; e.pvs = 1;
    add(0, 16'h1000, 1, 1, e, "beq_taken_ex");
    add(0, 16'h1000, 0, 1, f_if(1, 3), "beq_n_if");
    add(0, 16'h1000, 0, 1, f_id(3), "beq_n_id");
    e.cnt = 3; e.pc_src = 0;
    add(0, 16'h1000, 0, 1, e, "beq_not_taken_ex");

    add(0, 16'hA123, 0, 1, f_if(1, 4), "jal_if");
    e = f_id(4); e.pc_src = 2; e.reg_write = 1; e.reg_dst = 2; e.wb_src = 2; e.pvs = 1;
    add(0, 16'hA123, 0, 1, e, "jal_id");

    add(0, 16'hF01C, 0, 1, f_if(1, 5), "wwd_if");
    add(0, 16'hF01C, 0, 1, f_id(5), "wwd_id");
    e = mk(3'd2, 5, 0); e.oen = 1; e.pvs = 1;
    add(0, 16'hF01C, 0, 1, e, "wwd_ex");

    add(0, 16'hF019, 0, 1, f_if(1, 6), "jpr_if");
    e = f_id(6); e.pc_src = 3; e.pvs = 1;
    add(0, 16'hF019, 0, 1, e, "jpr_id");

    add(0, 16'hF01D, 0, 1, f_if(1, 7), "hlt_if");
    add(0, 16'hF01D, 0, 1, f_id(7), "hlt_id");

    reset = 1; opcode = 0; func = 0; bcond = 0; mem_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].ir, tbl[i].bc, tbl[i].rdy, tbl[i].e, tbl[i].nm);

    // ---- HALT holds, then reset clears it ----
    for (int i = 0; i < 10; i++) step(0, 16'hF01D, 0, 1, mk(3'd5, 8, 1), "halt_hold");
    step(1, 16'hF01D, 0, 1, mk(3'd5, 8, 1), "halt_reset_cycle");
    step(0, 16'h8000, 0, 1, f_if(1, 0), "after_halt_reset");

    // ---- SWD abandoned by reset while stalled in MEM ----
    step(0, 16'h8000, 0, 1, f_id(0), "swd_id");
    e = mk(3'd2, 0, 0); e.a_src = 1; e.b_src = 1; e.aluout = 1;
    step(0, 16'h8000, 0, 1, e, "swd_ex");
    e = mk(3'd3, 0, 0); e.i_or_d = 1; e.mem_write = 1;
    for (int i = 0; i < 2; i++) step(0, 16'h8000, 0, 0, e, "swd_mem_wait");
    step(1, 16'h8000, 0, 0, mk(3'd3, 0, 0), "swd_reset_in_mem");
    step(0, 16'h8000, 0, 0, f_if(0, 0), "swd_abandoned_if");

    // ---- SWD completing normally ----
    step(0, 16'h8000, 0, 1, f_if(1, 0), "swd2_if");
    step(0, 16'h8000, 0, 1, f_id(0), "swd2_id");
    e = mk(3'd2, 0, 0); e.a_src = 1; e.b_src = 1; e.aluout = 1;
    step(0, 16'h8000, 0, 1, e, "swd2_ex");
    e = mk(3'd3, 0, 0); e.i_or_d = 1; e.mem_write = 1; e.pvs = 1;
    step(0, 16'h8000, 0, 1, e, "swd2_mem_rdy");

    // ---- undefined opcode 0xB ----
    step(0, 16'hB000, 0, 1, f_if(1, 1), "undef_if");
`ifdef ILLEGAL_TRAP_EN
    step(0, 16'hB000, 0, 1, f_id(1), "undef_id_trap");
    e = mk(3'd5, 1, 1); e.ill = 1;
    for (int i = 0; i < 3; i++) step(0, 16'hB000, 0, 1, e, "undef_halt_illegal");
    step(1, 16'hB000, 0, 1, e, "undef_reset_cycle");
    step(0, 16'hF0C0, 0, 1, f_if(1, 0), "undef_cleared");
`else
    e = f_id(1); e.pvs = 1;
    step(0, 16'hB000, 0, 1, e, "undef_id_nop");
    step(0, 16'hF0C0, 0, 1, f_if(1, 2), "undef_retired_if");
`endif

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
